// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the instruction-fetch stage.
//   RESET_PC / EXC_PC / NOP_INST / PC_STEP : default fetch constants
//   if_id_t   : IF/ID pipeline register contents (pc, pc4, inst, valid)
//   pc_sel_t  : which source the next-PC mux picked this cycle
//   align_word: clears the two low address bits of a redirect target
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] EXC_PC   = 32'h0000_0180;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } if_id_t;

    typedef enum logic [2:0] {
        SEL_EXC,
        SEL_HOLD,
        SEL_PEND,
        SEL_REDIR,
        SEL_SEQ
    } pc_sel_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational priority select of the next fetch address.
// Ports:
//   exc_req     in   exception request, highest priority
//   stall       in   hold current PC
//   pend_valid  in   a redirect was buffered during a stall
//   pend_pc     in   buffered (aligned) redirect target
//   redirect    in   redirect from ID this cycle
//   redirect_pc in   redirect target, already word aligned
//   pc          in   current fetch address
//   next_pc     out  selected next fetch address
//   sel         out  which source was selected
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        exc_req,
    input  logic        stall,
    input  logic        pend_valid,
    input  logic [31:0] pend_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output pc_sel_t     sel
);

    // A fresh redirect is newer than a buffered one, so it is checked first.
    always_comb begin
        sel     = SEL_SEQ;
        next_pc = pc + PC_STEP;
        if (exc_req) begin
            sel     = SEL_EXC;
            next_pc = EXC_VECTOR;
        end else if (stall) begin
            sel     = SEL_HOLD;
            next_pc = pc;
        end else if (redirect) begin
            sel     = SEL_REDIR;
            next_pc = redirect_pc;
        end else if (pend_valid) begin
            sel     = SEL_PEND;
            next_pc = pend_pc;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage. Owns the PC, drives imem, and
// captures the returned instruction into the IF/ID pipeline register.
// Optional build macro IF_DELAY_SLOT_EN: keep the delay-slot instruction on
// a redirect instead of bubbling it.
// Ports:
//   clk, reset (async, active low)
//   stall, redirect, redirect_pc, exc_req : control from hazard/ID/later stages
//   inst        in   instruction word from imem for the current pc
//   pc, IM_R    out  fetch address and read enable to imem
//   if_id_pc, if_id_pc4, if_id_inst, if_id_valid : IF/ID register
//   fetch_cnt   out  number of valid instructions captured into IF/ID
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] EXC_PC   = cpu_pkg::EXC_PC,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc_req,
    input  logic [31:0] inst,
    output logic [31:0] pc,
    output logic        IM_R,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [31:0] fetch_cnt
);

    cpu_pkg::if_id_t  if_id_q;
    cpu_pkg::if_id_t  capture;
    cpu_pkg::if_id_t  bubble;
    cpu_pkg::pc_sel_t sel;

    logic        started;
    logic        pend_valid;
    logic [31:0] pend_pc;
    logic [31:0] next_pc;
    logic [31:0] redirect_pc_al;

    assign redirect_pc_al = cpu_pkg::align_word(redirect_pc);
    assign capture = '{pc: pc, pc4: pc + cpu_pkg::PC_STEP, inst: inst, valid: 1'b1};
    assign bubble  = '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0};

    pc_next_mux #(
        .EXC_VECTOR (EXC_PC)
    ) u_pc_next_mux (
        .exc_req     (exc_req),
        .stall       (stall),
        .pend_valid  (pend_valid),
        .pend_pc     (pend_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc_al),
        .pc          (pc),
        .next_pc     (next_pc),
        .sel         (sel)
    );

    // The first edge after reset only raises IM_R so that imem has a full
    // cycle to present the word at RESET_PC before it is captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            IM_R       <= 1'b0;
            started    <= 1'b0;
            if_id_q    <= '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0};
            pend_valid <= 1'b0;
            pend_pc    <= '0;
            fetch_cnt  <= '0;
        end else if (!started) begin
            started <= 1'b1;
            IM_R    <= 1'b1;
        end else begin
            pc <= next_pc;
            unique case (sel)
                cpu_pkg::SEL_EXC: begin
                    if_id_q    <= bubble;
                    pend_valid <= 1'b0;
                end
                cpu_pkg::SEL_HOLD: begin
                    if (redirect) begin
                        pend_pc    <= redirect_pc_al;
                        pend_valid <= 1'b1;
                    end
                end
                cpu_pkg::SEL_PEND, cpu_pkg::SEL_REDIR: begin
                    pend_valid <= 1'b0;
`ifdef IF_DELAY_SLOT_EN
                    if_id_q   <= capture;
                    fetch_cnt <= fetch_cnt + 32'd1;
`else
                    if_id_q   <= bubble;
`endif
                end
                cpu_pkg::SEL_SEQ: begin
                    if_id_q   <= capture;
                    fetch_cnt <= fetch_cnt + 32'd1;
                end
            endcase
        end
    end

    assign if_id_pc    = if_id_q.pc;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_inst  = if_id_q.inst;
    assign if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

`ifdef IF_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif
    localparam int DSI = DS ? 1 : 0;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        exc_req = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        IM_R;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [31:0] fetch_cnt;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exc_req     (exc_req),
        .inst        (inst),
        .pc          (pc),
        .IM_R        (IM_R),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_inst  (if_id_inst),
        .if_id_valid (if_id_valid),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    assign inst = imem_f(pc);

    // reference model state
    logic        m_started, m_imr, m_pend_v, m_ifid_v;
    logic [31:0] m_pc, m_pend_pc, m_ifid_pc, m_ifid_pc4, m_ifid_inst, m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_imr = 0; m_pc = 32'h0; m_pend_v = 0; m_pend_pc = 0;
        m_ifid_v = 0; m_ifid_pc = 0; m_ifid_pc4 = 0; m_ifid_inst = NOP; m_cnt = 0;
    endtask

    task automatic model_capture();
        m_ifid_pc   = m_pc;
        m_ifid_pc4  = m_pc + 32'd4;
        m_ifid_inst = imem_f(m_pc);
        m_ifid_v    = 1;
        m_cnt       = m_cnt + 32'd1;
    endtask

    task automatic model_bubble();
        m_ifid_v    = 0;
        m_ifid_inst = NOP;
    endtask

    // One clock edge worth of fetch-stage rules, applied in priority order.
    task automatic model_edge();
        logic [31:0] tgt;
        logic        take;
        if (!m_started) begin
            m_started = 1; m_imr = 1;
        end else if (exc_req) begin
            m_pc = 32'h180; model_bubble(); m_pend_v = 0;
        end else if (stall) begin
            if (redirect) begin
                m_pend_pc = redirect_pc & ~32'h3;
                m_pend_v  = 1;
            end
        end else begin
            take     = redirect || m_pend_v;
            tgt      = redirect ? (redirect_pc & ~32'h3) : m_pend_pc;
            m_pend_v = 0;
            if (take) begin
                if (DS) model_capture(); else model_bubble();
                m_pc = tgt;
            end else begin
                model_capture();
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_model();
        chk("rnd_pc", pc, m_pc);
        chk("rnd_im_r", {31'b0, IM_R}, {31'b0, m_imr});
        chk("rnd_valid", {31'b0, if_id_valid}, {31'b0, m_ifid_v});
        chk("rnd_inst", if_id_inst, m_ifid_inst);
        chk("rnd_cnt", fetch_cnt, m_cnt);
        if (m_ifid_v) begin
            chk("rnd_if_id_pc", if_id_pc, m_ifid_pc);
            chk("rnd_if_id_pc4", if_id_pc4, m_ifid_pc4);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_im_r"}, {31'b0, IM_R}, 32'h0);
        chk({tag, "_if_id_pc"}, if_id_pc, 32'h0);
        chk({tag, "_if_id_pc4"}, if_id_pc4, 32'h0);
        chk({tag, "_inst"}, if_id_inst, NOP);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
        chk({tag, "_cnt"}, fetch_cnt, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic e);
        stall = s; redirect = r; redirect_pc = rp; exc_req = e;
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        exc;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_ipc;
        logic [31:0] e_ipc4;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic e, input logic [31:0] epc, input logic ev,
                                input logic [31:0] eipc, input logic [31:0] eipc4,
                                input int ecnt);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rp; v.exc = e; v.e_pc = epc; v.e_v = ev;
        v.e_ipc = eipc; v.e_ipc4 = eipc4; v.e_cnt = 32'(ecnt);
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // directed sequence from reset release; one record per clock edge
        tbl[0]  = mk(0, 0, 0,            0, 32'h0,        0,  0,            0,            0);
        tbl[1]  = mk(0, 0, 0,            0, 32'h4,        1,  32'h0,        32'h4,        1);
        tbl[2]  = mk(0, 0, 0,            0, 32'h8,        1,  32'h4,        32'h8,        2);
        tbl[3]  = mk(0, 0, 0,            0, 32'hC,        1,  32'h8,        32'hC,        3);
        tbl[4]  = mk(0, 0, 0,            0, 32'h10,       1,  32'hC,        32'h10,       4);
        tbl[5]  = mk(0, 1, 32'h43,       0, 32'h40,       DS, 32'h10,       32'h14,       4 + DSI);
        tbl[6]  = mk(0, 0, 0,            0, 32'h44,       1,  32'h40,       32'h44,       5 + DSI);
        tbl[7]  = mk(1, 0, 0,            0, 32'h44,       1,  32'h40,       32'h44,       5 + DSI);
        tbl[8]  = mk(1, 1, 32'h80,       0, 32'h44,       1,  32'h40,       32'h44,       5 + DSI);
        tbl[9]  = mk(1, 0, 0,            0, 32'h44,       1,  32'h40,       32'h44,       5 + DSI);
        tbl[10] = mk(0, 0, 0,            0, 32'h80,       DS, 32'h44,       32'h48,       5 + 2*DSI);
        tbl[11] = mk(0, 0, 0,            0, 32'h84,       1,  32'h80,       32'h84,       6 + 2*DSI);
        tbl[12] = mk(1, 1, 32'h104,      0, 32'h84,       1,  32'h80,       32'h84,       6 + 2*DSI);
        tbl[13] = mk(1, 1, 32'h200,      1, 32'h180,      0,  0,            0,            6 + 2*DSI);
        tbl[14] = mk(0, 0, 0,            0, 32'h184,      1,  32'h180,      32'h184,      7 + 2*DSI);
        tbl[15] = mk(0, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFC, DS, 32'h184,      32'h188,      7 + 3*DSI);
        tbl[16] = mk(0, 0, 0,            0, 32'h0,        1,  32'hFFFFFFFC, 32'h0,        8 + 3*DSI);
        tbl[17] = mk(1, 1, 32'h300,      0, 32'h0,        1,  32'hFFFFFFFC, 32'h0,        8 + 3*DSI);
        tbl[18] = mk(0, 1, 32'h400,      0, 32'h400,      DS, 32'h0,        32'h4,        8 + 4*DSI);
        tbl[19] = mk(0, 0, 0,            0, 32'h404,      1,  32'h400,      32'h404,      9 + 4*DSI);

        #1;
        check_reset("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].exc);
            step();
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_im_r", i), {31'b0, IM_R}, 32'h1);
            chk($sformatf("tbl%0d_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].e_v});
            chk($sformatf("tbl%0d_cnt", i), fetch_cnt, tbl[i].e_cnt);
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_if_id_pc", i), if_id_pc, tbl[i].e_ipc);
                chk($sformatf("tbl%0d_if_id_pc4", i), if_id_pc4, tbl[i].e_ipc4);
                chk($sformatf("tbl%0d_inst", i), if_id_inst, imem_f(tbl[i].e_ipc));
            end else begin
                chk($sformatf("tbl%0d_inst", i), if_id_inst, NOP);
            end
        end

        // asynchronous reset while a redirect is buffered
        drive(1, 1, 32'h500, 0);
        step();
        chk("midrst_pre_pc", pc, 32'h404);
        drive(0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("restart1_pc", pc, 32'h0);
        chk("restart1_valid", {31'b0, if_id_valid}, 32'h0);
        step();
        chk("restart2_pc", pc, 32'h4);
        chk("restart2_valid", {31'b0, if_id_valid}, 32'h1);
        chk("restart2_if_id_pc", if_id_pc, 32'h0);
        chk("restart2_cnt", fetch_cnt, 32'h1);

        // randomized traffic against the reference model
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, $urandom,
                  $urandom_range(0, 19) == 0);
            step();
            compare_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
